// File: rtl/sysid_probe_master.sv
// sysid_probe_master: Avalon-MM read master that fetches the system ID (word 0)
// and build timestamp (word 1), compares both against expected values and
// reports pass/fail, the captured words and an error code.
module sysid_probe_master #(
  parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1327904020,
  parameter logic [15:0] TIMEOUT_CYCLES     = 16'd255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [1:0]  error,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ID_REQ,
    S_ID_WAIT,
    S_TS_REQ,
    S_TS_WAIT,
    S_DONE
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ID      = 2'b01;
  localparam logic [1:0] ERR_TS      = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  // Last counter value a transaction may reach before it is abandoned.
  localparam logic [15:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 16'd1;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        avm_read_q, avm_read_d;
  logic        avm_address_q, avm_address_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [1:0]  error_q, error_d;
  logic [31:0] id_value_q, id_value_d;
  logic [31:0] ts_value_q, ts_value_d;
  logic        timeout_hit;

  assign timeout_hit = (cnt_q == TIMEOUT_LAST);

  // Next-state, capture and result logic; bus/status outputs are derived from
  // the next state so that every output comes straight from a flop.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pass_d     = pass_q;
    error_d    = error_q;
    id_value_d = id_value_q;
    ts_value_d = ts_value_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_ID_REQ;
          cnt_d      = 16'd0;
          pass_d     = 1'b0;
          error_d    = ERR_NONE;
          id_value_d = 32'd0;
          ts_value_d = 32'd0;
        end
      end
      S_ID_REQ, S_TS_REQ: begin
        cnt_d = cnt_q + 16'd1;
        // Timeout takes priority over a request accepted in the same cycle.
        if (timeout_hit) begin
          state_d = S_DONE;
          error_d = ERR_TIMEOUT;
          pass_d  = 1'b0;
        end else if (!avm_waitrequest) begin
          state_d = (state_q == S_ID_REQ) ? S_ID_WAIT : S_TS_WAIT;
        end
      end
      S_ID_WAIT: begin
        cnt_d = cnt_q + 16'd1;
        // A response arriving on the timeout cycle still counts.
        if (avm_readdatavalid) begin
          id_value_d = avm_readdata;
          if (avm_readdata == EXPECTED_ID) begin
            state_d = S_TS_REQ;
            cnt_d   = 16'd0;
          end else begin
            state_d = S_DONE;
            error_d = ERR_ID;
          end
        end else if (timeout_hit) begin
          state_d = S_DONE;
          error_d = ERR_TIMEOUT;
          pass_d  = 1'b0;
        end
      end
      S_TS_WAIT: begin
        cnt_d = cnt_q + 16'd1;
        if (avm_readdatavalid) begin
          ts_value_d = avm_readdata;
          state_d    = S_DONE;
          if (avm_readdata == EXPECTED_TIMESTAMP) begin
            pass_d  = 1'b1;
            error_d = ERR_NONE;
          end else begin
            error_d = ERR_TS;
          end
        end else if (timeout_hit) begin
          state_d = S_DONE;
          error_d = ERR_TIMEOUT;
          pass_d  = 1'b0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    avm_read_d    = (state_d == S_ID_REQ) || (state_d == S_TS_REQ);
    avm_address_d = (state_d == S_TS_REQ);
    busy_d        = (state_d == S_ID_REQ) || (state_d == S_ID_WAIT) ||
                    (state_d == S_TS_REQ) || (state_d == S_TS_WAIT);
    done_d        = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= 16'd0;
      avm_read_q    <= 1'b0;
      avm_address_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      error_q       <= ERR_NONE;
      id_value_q    <= 32'd0;
      ts_value_q    <= 32'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      avm_read_q    <= avm_read_d;
      avm_address_q <= avm_address_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      error_q       <= error_d;
      id_value_q    <= id_value_d;
      ts_value_q    <= ts_value_d;
    end
  end

  assign avm_read    = avm_read_q;
  assign avm_address = avm_address_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign error       = error_q;
  assign id_value    = id_value_q;
  assign ts_value    = ts_value_q;

endmodule

// File: tb/tb_sysid_probe_master.sv
// Testbench for sysid_probe_master: a configurable sysid slave model, a
// randomized probe generator with a transaction-level outcome predictor, and a
// done-driven monitor that pops predictions from a scoreboard queue.
module tb_sysid_probe_master;

  localparam logic [31:0] EXP_ID = 32'h0000_0000;
  localparam logic [31:0] EXP_TS = 32'd1327904020;
  localparam int          TO     = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic        busy;
  logic        done;
  logic        pass;
  logic [1:0]  error;
  logic [31:0] id_value;
  logic [31:0] ts_value;

  sysid_probe_master #(
    .EXPECTED_ID       (EXP_ID),
    .EXPECTED_TIMESTAMP(EXP_TS),
    .TIMEOUT_CYCLES    (16'd8)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .avm_address      (avm_address),
    .avm_read         (avm_read),
    .avm_waitrequest  (avm_waitrequest),
    .avm_readdata     (avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .error            (error),
    .id_value         (id_value),
    .ts_value         (ts_value)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic        pass;
    logic [1:0]  err;
    logic [31:0] id;
    logic [31:0] ts;
    int          lat;
    int          reads;
    int          acc_base;
    int          start_cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t hold_exp;

  int vectors     = 0;
  int miscompares = 0;
  int done_cnt    = 0;
  int accepted    = 0;
  int stray_req   = 0;
  int chk_busy_cyc = -1;
  int chk_zero_cyc = -1;
  int chk_hold_cyc = -1;

  // Per-word slave behaviour for the probe in flight.
  int          cfg_w[2];
  int          cfg_l[2];
  bit          cfg_r[2];
  logic [31:0] cfg_d[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Outcome of one probe from the slave configuration: a read with w wait
  // cycles and latency l delivers its data on cycle w+1+l of its transaction,
  // and the transaction is abandoned after TO cycles.
  function automatic exp_t predict();
    exp_t e;
    int   t;
    int   idx;
    e = '{default: 0};
    t = 0;
    for (int a = 0; a < 2; a++) begin
      if (cfg_w[a] + 1 <= TO) e.reads++;
      idx = cfg_w[a] + 1 + cfg_l[a];
      if (cfg_r[a] && idx <= TO) begin
        t += idx;
        if (a == 0) e.id = cfg_d[0];
        else        e.ts = cfg_d[1];
        if (cfg_d[a] != ((a == 0) ? EXP_ID : EXP_TS)) begin
          e.err = (a == 0) ? 2'b01 : 2'b10;
          break;
        end
        if (a == 1) e.pass = 1'b1;
      end else begin
        t += TO;
        e.err = 2'b11;
        break;
      end
    end
    e.lat = t + 1;
    return e;
  endfunction

  // Slave model: drives waitrequest/readdatavalid just after each clock edge.
  initial begin : slave
    int          wait_left;
    int          lat_cnt;
    bit          in_req;
    bit          resp_en;
    logic        req_addr;
    logic [31:0] resp_data;
    int          stray_ack;
    wait_left = 0; lat_cnt = 0; in_req = 0; resp_en = 0; req_addr = 0;
    resp_data = 0; stray_ack = 0;
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata      = 32'd0;
    forever begin
      @(posedge clock); #1;
      avm_readdatavalid = 1'b0;
      avm_readdata      = $urandom;
      if (lat_cnt > 0) begin
        lat_cnt--;
        if (lat_cnt == 0 && resp_en) begin
          avm_readdatavalid = 1'b1;
          avm_readdata      = resp_data;
        end
      end
      if (stray_req != stray_ack) begin
        stray_ack         = stray_req;
        avm_readdatavalid = 1'b1;
      end
      if (avm_read) begin
        if (!in_req) begin
          in_req    = 1'b1;
          req_addr  = avm_address;
          wait_left = cfg_w[req_addr];
        end else begin
          check("addr_stable", 32'(avm_address), 32'(req_addr));
        end
        if (wait_left > 0) begin
          avm_waitrequest = 1'b1;
          wait_left--;
        end else begin
          avm_waitrequest = 1'b0;
          in_req          = 1'b0;
          accepted++;
          lat_cnt   = cfg_l[req_addr];
          resp_en   = cfg_r[req_addr];
          resp_data = cfg_d[req_addr];
        end
      end else begin
        in_req          = 1'b0;
        avm_waitrequest = 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor: compares every completion against the oldest prediction, plus
  // scheduled spot checks of the status outputs.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (cyc == chk_zero_cyc) begin
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_id", id_value, 32'd0);
        check("rst_ts", ts_value, 32'd0);
        check("rst_read", 32'(avm_read), 32'd0);
        check("rst_addr", 32'(avm_address), 32'd0);
      end
      if (cyc == chk_busy_cyc) begin
        check("start_busy", 32'(busy), 32'd1);
        check("start_pass_clr", 32'(pass), 32'd0);
        check("start_err_clr", 32'(error), 32'd0);
        check("start_id_clr", id_value, 32'd0);
      end
      if (cyc == chk_hold_cyc) begin
        check("hold_pass", 32'(pass), 32'(hold_exp.pass));
        check("hold_error", 32'(error), 32'(hold_exp.err));
        check("hold_id", id_value, hold_exp.id);
        check("hold_ts", ts_value, hold_exp.ts);
        check("hold_busy", 32'(busy), 32'd0);
      end
      if (!reset && done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("pass", 32'(pass), 32'(e.pass));
          check("error", 32'(error), 32'(e.err));
          check("id_value", id_value, e.id);
          check("ts_value", ts_value, e.ts);
          check("latency", 32'(cyc - e.start_cyc), 32'(e.lat));
          check("reads", 32'(accepted - e.acc_base), 32'(e.reads));
          check("done_busy", 32'(busy), 32'd0);
          $display("probe done: pass=%0d err=%0d id=%h ts=%h lat=%0d",
                   pass, error, id_value, ts_value, cyc - e.start_cyc);
        end
        done_cnt++;
        @(negedge clock);
        check("done_pulse", 32'(done), 32'd0);
      end
    end
  end

  task automatic run_probe(input int w0, input int l0, input bit r0, input logic [31:0] d0,
                           input int w1, input int l1, input bit r1, input logic [31:0] d1,
                           input bit mid_start, input bit stray);
    exp_t e;
    int   target;
    int   n;
    cfg_w[0] = w0; cfg_l[0] = l0; cfg_r[0] = r0; cfg_d[0] = d0;
    cfg_w[1] = w1; cfg_l[1] = l1; cfg_r[1] = r1; cfg_d[1] = d1;
    e = predict();
    target = done_cnt + 1;
    @(posedge clock); #1;
    e.start_cyc = cyc;
    e.acc_base  = accepted;
    exp_q.push_back(e);
    chk_busy_cyc = cyc + 1;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    if (mid_start) begin
      @(posedge clock); #1;
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
    end
    n = 0;
    while (done_cnt < target && n < 200) begin
      @(posedge clock);
      n++;
    end
    if (done_cnt < target) check("done_timeout", 32'(done_cnt), 32'(target));
    if (stray) stray_req++;
    hold_exp = e;
    @(posedge clock); #1;
    chk_hold_cyc = cyc + 5;
    repeat (7) @(posedge clock);
  endtask

  function automatic logic [31:0] pick_data(input bit good, input logic [31:0] want);
    logic [31:0] flip;
    flip = 32'h1 << $urandom_range(0, 31);
    return good ? want : (want ^ flip);
  endfunction

  initial begin : stimulus
    int T;
    int w0, w1, l0, l1;
    bit r0, r1, g0, g1;
    cfg_w = '{0, 0}; cfg_l = '{1, 1}; cfg_r = '{1, 1}; cfg_d = '{EXP_ID, EXP_TS};
    reset = 1'b1;
    repeat (3) begin @(posedge clock); #1; end
    chk_zero_cyc = cyc;
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (2) @(posedge clock);

    run_probe(0, 1, 1, EXP_ID, 0, 1, 1, EXP_TS, 0, 0);       // nominal
    run_probe(3, 1, 1, EXP_ID, 3, 1, 1, EXP_TS, 0, 0);       // wait states
    run_probe(0, 1, 1, 32'h1, 0, 1, 1, EXP_TS, 0, 0);        // ID mismatch
    run_probe(0, 1, 1, EXP_ID, 0, 1, 1, 32'h0, 0, 0);        // TS mismatch
    run_probe(0, 1, 0, EXP_ID, 0, 1, 1, EXP_TS, 0, 1);       // timeout + stray
    run_probe(0, 1, 1, EXP_ID, 0, 1, 1, EXP_TS, 1, 0);       // start mid-probe
    run_probe(0, 1, 1, EXP_ID, 0, 1, 1, EXP_TS, 0, 0);       // re-probe after pass
    run_probe(7, 1, 1, EXP_ID, 0, 1, 1, EXP_TS, 0, 0);       // accept on timeout cycle
    run_probe(0, 1, 1, EXP_ID, 2, 5, 1, EXP_TS, 0, 0);       // response on timeout cycle

    for (int i = 0; i < 40; i++) begin
      w0 = ($urandom_range(0, 4) == 0) ? $urandom_range(5, 9) : $urandom_range(0, 4);
      w1 = ($urandom_range(0, 4) == 0) ? $urandom_range(5, 9) : $urandom_range(0, 4);
      l0 = $urandom_range(1, 3);
      l1 = $urandom_range(1, 3);
      r0 = ($urandom_range(0, 9) != 0);
      r1 = ($urandom_range(0, 9) != 0);
      g0 = ($urandom_range(0, 3) != 0);
      g1 = ($urandom_range(0, 3) != 0);
      run_probe(w0, l0, r0, pick_data(g0, EXP_ID), w1, l1, r1, pick_data(g1, EXP_TS),
                ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
    end

    // Reset while waiting for the timestamp response; the late response must
    // not disturb the cleared outputs and no completion may follow.
    cfg_w[0] = 0; cfg_l[0] = 1; cfg_r[0] = 1; cfg_d[0] = EXP_ID;
    cfg_w[1] = 0; cfg_l[1] = 5; cfg_r[1] = 1; cfg_d[1] = EXP_TS;
    @(posedge clock); #1;
    T = cyc;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    while (cyc < T + 5) begin @(posedge clock); #1; end
    reset = 1'b1;
    chk_zero_cyc = T + 6;
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    chk_zero_cyc = T + 10;
    repeat (8) @(posedge clock);

    run_probe(0, 1, 1, EXP_ID, 0, 1, 1, EXP_TS, 0, 0);       // recovers after reset
    repeat (4) @(posedge clock);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
